// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a core MEM stage and an
// Avalon-MM data port. Handles one request at a time. Stores get byte
// enables and lane shifting. Loads get beat merging and zero or sign
// extension. An access that crosses a word boundary is either split into
// two bus beats or reported as an error, depending on MISALIGN_EN.
module mem_access_unit #(
  parameter int N           = 64,    // data width, 32 or 64
  parameter int AW          = 32,    // byte-address width
  parameter bit MISALIGN_EN = 1'b1   // 1: split word-crossing accesses, 0: error
) (
  input  logic            clk,
  input  logic            reset,
  // core request / response
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [2:0]      req_width,
  input  logic            req_unsigned,
  input  logic [N-1:0]    req_wdata,
  output logic            rsp_valid,
  output logic [N-1:0]    rsp_rdata,
  output logic            rsp_error,
  // Avalon-MM host
  output logic [AW-1:0]   avm_address,
  output logic [N/8-1:0]  avm_byteenable,
  output logic [N-1:0]    avm_writedata,
  output logic            avm_write,
  output logic            avm_read,
  input  logic            avm_waitrequest,
  input  logic [N-1:0]    avm_readdata,
  input  logic            avm_readdatavalid
);

  localparam int BYTES = N / 8;
  localparam int SB    = $clog2(BYTES);
  localparam bit D_OK  = (N == 64);   // doubleword only exists on a 64-bit port

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,     // lower-word beat on the bus
    S_W0,     // waiting for lower-word read data
    S_B1,     // upper-word beat on the bus
    S_W1,     // waiting for upper-word read data
    S_DONE,   // completion pulse
    S_ERR     // error pulse, no bus access was made
  } state_t;

  state_t state;

  // Captured request fields
  logic [SB-1:0]    q_sel;
  logic [2:0]       q_width;
  logic             q_unsigned;
  logic             q_write;
  logic             q_split;
  logic [AW-1:0]    q_addr1;
  logic [BYTES-1:0] q_be_hi;
  logic [N-1:0]     q_wd_hi;
  logic [N-1:0]     q_lo;      // lower-word read data of a split load

  // Lane arithmetic on the incoming request
  logic [SB-1:0]      in_sel;
  logic [7:0]         in_mask8;
  logic [BYTES-1:0]   in_mask;
  logic [2*BYTES-1:0] in_be2;
  logic [2*N-1:0]     in_wd2;
  logic               in_split;
  logic               in_legal;
  logic               in_error;

  // Load merge and extension
  logic [N-1:0] rd_lo;
  logic [N-1:0] rd_hi;
  logic [N-1:0] rd_sh;
  logic [7:0]   q_mask8;
  logic [N-1:0] bit_mask;
  logic         sign_bit;
  logic [N-1:0] ext_data;

  // Derive byte enables, shifted store data and the error decision for the request on the port
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    in_legal = 1'b0;
    in_sel   = req_addr[SB-1:0];
    in_mask8 = {{4{req_width[2]}}, {2{req_width[1]}}, req_width[0], 1'b1};
    in_mask  = in_mask8[BYTES-1:0];
    in_be2   = {{BYTES{1'b0}}, in_mask} << in_sel;
    in_wd2   = {{N{1'b0}}, req_wdata} << {in_sel, 3'b000};
    in_split = |in_be2[2*BYTES-1:BYTES];
    case (req_width)
      3'b000, 3'b001, 3'b011: in_legal = 1'b1;
      3'b111:                 in_legal = D_OK;
      default:                in_legal = 1'b0;
    endcase
    in_error = !in_legal || (in_split && !MISALIGN_EN);
  end

  // Merge the beat data, shift the addressed bytes down, then zero/sign extend
  always_comb begin
    rd_lo    = (state == S_W1) ? q_lo : avm_readdata;
    rd_hi    = (state == S_W1) ? avm_readdata : '0;
    rd_sh    = N'({rd_hi, rd_lo} >> {q_sel, 3'b000});
    q_mask8  = {{4{q_width[2]}}, {2{q_width[1]}}, q_width[0], 1'b1};
    bit_mask = '0;
    for (int i = 0; i < N; i++) begin
      bit_mask[i] = q_mask8[i/8];
    end
    case (q_width)
      3'b000:  sign_bit = rd_sh[7];
      3'b001:  sign_bit = rd_sh[15];
      3'b011:  sign_bit = rd_sh[31];
      default: sign_bit = rd_sh[N-1];
    endcase
    ext_data = (rd_sh & bit_mask) | (~bit_mask & {N{sign_bit & ~q_unsigned}});
  end

  // Access sequencer: all bus and response outputs are registered here
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      q_sel          <= '0;
      q_width        <= '0;
      q_unsigned     <= 1'b0;
      q_write        <= 1'b0;
      q_split        <= 1'b0;
      q_addr1        <= '0;
      q_be_hi        <= '0;
      q_wd_hi        <= '0;
      q_lo           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            q_sel      <= in_sel;
            q_width    <= req_width;
            q_unsigned <= req_unsigned;
            q_write    <= req_write;
            q_split    <= in_split;
            q_addr1    <= {req_addr[AW-1:SB], {SB{1'b0}}} + AW'(BYTES);
            q_be_hi    <= in_be2[2*BYTES-1:BYTES];
            q_wd_hi    <= in_wd2[2*N-1:N];
            if (in_error) begin
              state     <= S_ERR;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state          <= S_B0;
              avm_address    <= {req_addr[AW-1:SB], {SB{1'b0}}};
              avm_byteenable <= in_be2[BYTES-1:0];
              avm_writedata  <= req_write ? in_wd2[N-1:0] : '0;
              avm_write      <= req_write;
              avm_read       <= !req_write;
            end
          end
        end

        S_B0: begin
          if (!avm_waitrequest) begin
            if (q_write && q_split) begin
              state          <= S_B1;
              avm_address    <= q_addr1;
              avm_byteenable <= q_be_hi;
              avm_writedata  <= q_wd_hi;
            end else begin
              avm_write      <= 1'b0;
              avm_read       <= 1'b0;
              avm_address    <= '0;
              avm_byteenable <= '0;
              avm_writedata  <= '0;
              if (q_write) begin
                state     <= S_DONE;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
              end else begin
                state <= S_W0;
              end
            end
          end
        end

        S_W0: begin
          if (avm_readdatavalid) begin
            q_lo <= avm_readdata;
            if (q_split) begin
              state          <= S_B1;
              avm_read       <= 1'b1;
              avm_address    <= q_addr1;
              avm_byteenable <= q_be_hi;
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_rdata <= ext_data;
            end
          end
        end

        S_B1: begin
          if (!avm_waitrequest) begin
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            if (q_write) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= S_W1;
            end
          end
        end

        S_W1: begin
          if (avm_readdatavalid) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= ext_data;
          end
        end

        S_DONE, S_ERR: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= '0;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
